// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arb_pkg
// Brief   : States, owner encoding and line-geometry helpers for mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int BURST_LEN_DFLT = 4;
    localparam int OFFSET_W       = $clog2(BURST_LEN_DFLT) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IC   = 2'd1,
        OWN_DC   = 2'd2
    } arb_owner_t;

    // Byte-offset field width of a line holding burst_len 32-bit words.
    function automatic int offset_w(input int burst_len);
        return $clog2(burst_len) + 2;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/type_pkg.sv
`default_nettype none
// ============================================================================
// Package : type_pkg
// Brief   : Shared machine word types for the memory subsystem.
// Rev     : 1.0  initial release
// ============================================================================
package type_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

endpackage : type_pkg
`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb_pick
// Brief   : Combinational winner select between icache and dcache requests.
// Options : MEM_ARBITER_ROUND_ROBIN_EN - tie goes to the side not granted last
// Rev     : 1.0  initial release
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_req,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    input  logic       last_dc,
`endif
    output arb_owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
        if (ic_req && dc_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            winner = last_dc ? OWN_IC : OWN_DC;
`else
            winner = OWN_DC;
`endif
        end else if (dc_req) begin
            winner = OWN_DC;
        end else if (ic_req) begin
            winner = OWN_IC;
        end
    end

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares the memory word port between icache and dcache line bursts.
// Options : MEM_ARBITER_ROUND_ROBIN_EN - round-robin tie breaking
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
    import type_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DFLT,
    parameter int ADDR_W    = $bits(addr_t),
    parameter int DATA_W    = $bits(data_t)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_done,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                  c_beat_w    = $clog2(BURST_LEN);
    localparam int                  c_offset_w  = offset_w(BURST_LEN);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]   c_line_mask =
        ~((ADDR_W'(1) << c_offset_w) - ADDR_W'(1));

    arb_state_t          r_state;
    arb_owner_t          r_owner;
    logic [c_beat_w-1:0] r_beat;
    logic [ADDR_W-1:0]   r_base;
    logic                r_we;
    arb_owner_t          w_winner;
    logic                w_busy;
    logic                w_beat_done;
    logic                w_rd_beat;
    logic                w_done;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic                r_last_dc;
`endif

    arb_pick u_pick (
        .ic_req  (ic_req),
        .dc_req  (dc_req),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        .last_dc (r_last_dc),
`endif
        .winner  (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_NONE;
            r_beat    <= '0;
            r_base    <= '0;
            r_we      <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            r_last_dc <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_winner != OWN_NONE) begin
                        r_owner <= w_winner;
                        r_base  <= ((w_winner == OWN_DC) ? dc_addr : ic_addr) & c_line_mask;
                        r_we    <= (w_winner == OWN_DC) && dc_we;
                        r_beat  <= '0;
                        r_state <= BUSY;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        r_last_dc <= (w_winner == OWN_DC);
`endif
                    end
                end
                BUSY: begin
                    // Counter wraps back to zero on the last beat by width alone.
                    if (mem_ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == c_last_beat) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    assign w_busy      = (r_state == BUSY);
    assign w_beat_done = w_busy && mem_ready;
    assign w_rd_beat   = w_beat_done && !r_we;
    assign w_done      = (r_state == DONE);

    // The offset field never carries into the line base, so OR-free add is safe.
    assign mem_valid = w_busy;
    assign mem_we    = w_busy && r_we;
    assign mem_addr  = w_busy
                     ? r_base + {{(ADDR_W - c_offset_w){1'b0}}, r_beat, 2'b00}
                     : '0;
    assign mem_wdata = w_busy ? dc_wdata : '0;

    assign ic_rvalid = w_rd_beat && (r_owner == OWN_IC);
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rvalid = w_rd_beat && (r_owner == OWN_DC);
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
    assign dc_wnext  = w_beat_done && r_we;

    assign ic_done   = w_done && (r_owner == OWN_IC);
    assign dc_done   = w_done && (r_owner == OWN_DC);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter with a transaction-level model.
// Options : MEM_ARBITER_ROUND_ROBIN_EN - model follows round-robin tie rule
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata = '0;
    logic        ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done, mem_valid, mem_we;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;
    bit model_last_dc = 1'b0;

    mem_arbiter #(.BURST_LEN(BL), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Tie winner from the arbitration rule: dcache unless it was granted last (round robin).
    function automatic bit tie_goes_dc();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        return !model_last_dc;
`else
        return 1'b1;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1; mem_ready = 1'b1;
        mem_rdata = $urandom; dc_wdata = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done, mem_valid, mem_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got=%b expected=0000000",
                     {ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done, mem_valid, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || ic_rdata !== 32'h0 || dc_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h ic_rdata=%h dc_rdata=%h expected all 0",
                     mem_addr, mem_wdata, ic_rdata, dc_rdata);
        end
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        model_last_dc = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: mem_valid=%b expected 0", mem_valid);
        end
        next_cycle();
    endtask

    task automatic test_ic_refill();
        ic_addr = 32'h0000_1234; ic_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL ic_grant_cycle: mem_valid=%b expected 0", mem_valid);
        end
        next_cycle();
        model_last_dc = 1'b0;
        for (int i = 0; i < BL; i++) begin
            mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h1230 + 32'(4 * i)) begin
                errors++;
                $display("FAIL ic_beat%0d_addr: valid=%b we=%b addr=%h expected 1 0 %h",
                         i, mem_valid, mem_we, mem_addr, 32'h1230 + 32'(4 * i));
            end
            checks++;
            if (ic_rvalid !== 1'b1 || ic_rdata !== mem_rdata || dc_rvalid !== 1'b0 || ic_done !== 1'b0) begin
                errors++;
                $display("FAIL ic_beat%0d_data: rvalid=%b rdata=%h dc_rvalid=%b done=%b expected 1 %h 0 0",
                         i, ic_rvalid, ic_rdata, dc_rvalid, ic_done, mem_rdata);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (ic_done !== 1'b1 || dc_done !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL ic_done: ic_done=%b dc_done=%b valid=%b expected 1 0 0", ic_done, dc_done, mem_valid);
        end
        ic_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (ic_done !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL ic_done_width: ic_done=%b valid=%b expected 0 0", ic_done, mem_valid);
        end
        next_cycle();
    endtask

    task automatic test_dc_writeback();
        int wnext_cnt = 0;
        int done_cnt = 0;
        int rvalid_cnt = 0;
        dc_addr = 32'h0000_2000; dc_we = 1'b1; dc_req = 1'b1; mem_ready = 1'b0;
        dc_wdata = $urandom;
        next_cycle();
        model_last_dc = 1'b1;
        for (int b = 0; b < BL; b++) begin
            for (int s = 0; s < 3; s++) begin
                mem_ready = (s == 2);
                @(negedge clk);
                checks++;
                if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 + 32'(4 * b) ||
                    mem_wdata !== dc_wdata) begin
                    errors++;
                    $display("FAIL dc_wr_beat%0d: valid=%b we=%b addr=%h wdata=%h expected 1 1 %h %h",
                             b, mem_valid, mem_we, mem_addr, mem_wdata, 32'h2000 + 32'(4 * b), dc_wdata);
                end
                checks++;
                if (dc_wnext !== mem_ready) begin
                    errors++;
                    $display("FAIL dc_wnext_b%0d_s%0d: got=%b expected %b", b, s, dc_wnext, mem_ready);
                end
                if (dc_wnext) begin
                    wnext_cnt++;
                    dc_wdata = $urandom;
                end
                if (dc_rvalid) rvalid_cnt++;
                if (dc_done) done_cnt++;
                next_cycle();
            end
        end
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dc_wnext) wnext_cnt++;
            if (dc_done) begin
                done_cnt++;
                dc_req = 1'b0;
            end
            next_cycle();
        end
        dc_we = 1'b0;
        checks++;
        if (wnext_cnt != BL || done_cnt != 1 || rvalid_cnt != 0) begin
            errors++;
            $display("FAIL dc_wr_counts: wnext=%0d done=%0d rvalid=%0d expected %0d 1 0",
                     wnext_cnt, done_cnt, rvalid_cnt, BL);
        end
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            bit first_dc = tie_goes_dc();
            ic_addr = 32'h0000_3004; dc_addr = 32'h0000_4018; dc_we = 1'b0;
            ic_req = 1'b1; dc_req = 1'b1; mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL tie%0d_grant: mem_valid=%b expected 0", r, mem_valid);
            end
            next_cycle();
            for (int slot = 0; slot < 2; slot++) begin
                bit own_dc = (slot == 0) ? first_dc : !first_dc;
                logic [31:0] base = own_dc ? 32'h4010 : 32'h3000;
                model_last_dc = own_dc;
                for (int i = 0; i < BL; i++) begin
                    mem_rdata = $urandom;
                    @(negedge clk);
                    checks++;
                    if (mem_addr !== base + 32'(4 * i) || {ic_rvalid, dc_rvalid} !== {!own_dc, own_dc} ||
                        (own_dc ? dc_rdata : ic_rdata) !== mem_rdata) begin
                        errors++;
                        $display("FAIL tie%0d_slot%0d_beat%0d: addr=%h ic_rv=%b dc_rv=%b expected %h own_dc=%b",
                                 r, slot, i, mem_addr, ic_rvalid, dc_rvalid, base + 32'(4 * i), own_dc);
                    end
                    next_cycle();
                end
                @(negedge clk);
                checks++;
                if ({ic_done, dc_done} !== {!own_dc, own_dc}) begin
                    errors++;
                    $display("FAIL tie%0d_slot%0d_done: ic_done=%b dc_done=%b expected %b %b",
                             r, slot, ic_done, dc_done, !own_dc, own_dc);
                end
                if (own_dc) dc_req = 1'b0; else ic_req = 1'b0;
                next_cycle();
                if (slot == 0) begin
                    @(negedge clk);
                    checks++;
                    if (mem_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL tie%0d_regrant_idle: mem_valid=%b expected 0", r, mem_valid);
                    end
                    next_cycle();
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        ic_addr = 32'h0000_5000; ic_req = 1'b1; mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        ic_req = 1'b0;
        #1;
        checks++;
        if ({ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done, mem_valid, mem_we} !== 7'b0 ||
            mem_addr !== 32'h0 || ic_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b rvalid=%b addr=%h expected all 0",
                     mem_valid, ic_rvalid, mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ic_done || dc_done) done_cnt++;
            next_cycle();
        end
        rst_n = 1'b1;
        model_last_dc = 1'b0;
        ic_addr = 32'h0000_6008; ic_req = 1'b1;
        @(negedge clk);
        if (ic_done || dc_done) done_cnt++;
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done pulses=%0d expected 0", done_cnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h6000 || ic_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart: valid=%b addr=%h rvalid=%b expected 1 00006000 1",
                     mem_valid, mem_addr, ic_rvalid);
        end
        repeat (4) next_cycle();
        @(negedge clk);
        checks++;
        if (ic_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_done: ic_done=%b expected 1", ic_done);
        end
        ic_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_drop();
        int beats = 0;
        ic_addr = 32'h0000_700C; ic_req = 1'b1; mem_ready = 1'b1;
        next_cycle();
        model_last_dc = 1'b0;
        for (int i = 0; i < BL; i++) begin
            if (i == 2) ic_req = 1'b0;
            @(negedge clk);
            if (ic_rvalid && mem_addr == 32'h7000 + 32'(4 * i)) beats++;
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (beats != BL || ic_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_mid_burst: beats=%0d ic_done=%b expected %0d 1", beats, ic_done, BL);
        end
        next_cycle();
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int pat = $urandom_range(1, 3);
            logic [31:0] ic_a = $urandom;
            logic [31:0] dc_a = $urandom;
            bit dc_w = 1'($urandom_range(0, 1));
            bit ic_p = pat[0];
            bit dc_p = pat[1];
            int cur = 0;
            int beats = 0;
            int cyc = 0;
            logic [31:0] exp_base = '0;
            bit exp_we = 1'b0;
            logic [2:0] exp_vec;
            ic_addr = ic_a; dc_addr = dc_a; dc_we = dc_w; ic_req = ic_p; dc_req = dc_p;
            while ((ic_p || dc_p) && cyc < 200) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                mem_rdata = $urandom;
                dc_wdata = $urandom;
                @(negedge clk);
                cyc++;
                if (mem_valid) begin
                    if (cur == 0) begin
                        if (ic_p && dc_p) cur = tie_goes_dc() ? 2 : 1;
                        else cur = dc_p ? 2 : 1;
                        model_last_dc = (cur == 2);
                        beats = 0;
                        exp_base = ((cur == 2) ? dc_a : ic_a) & ~32'hF;
                        exp_we = (cur == 2) && dc_w;
                    end
                    checks++;
                    if (mem_addr !== exp_base + 32'(4 * beats) || mem_we !== exp_we || mem_wdata !== dc_wdata) begin
                        errors++;
                        $display("FAIL rnd%0d_beat%0d_bus: addr=%h we=%b expected %h %b",
                                 t, beats, mem_addr, mem_we, exp_base + 32'(4 * beats), exp_we);
                    end
                    exp_vec = mem_ready ? {cur == 1, (cur == 2) && !exp_we, (cur == 2) && exp_we} : 3'b000;
                    checks++;
                    if ({ic_rvalid, dc_rvalid, dc_wnext} !== exp_vec ||
                        (ic_rvalid && ic_rdata !== mem_rdata) || (dc_rvalid && dc_rdata !== mem_rdata)) begin
                        errors++;
                        $display("FAIL rnd%0d_beat%0d_resp: ic_rv,dc_rv,wnext=%b expected %b",
                                 t, beats, {ic_rvalid, dc_rvalid, dc_wnext}, exp_vec);
                    end
                    if (mem_ready) beats++;
                end
                if (ic_done || dc_done) begin
                    checks++;
                    if (cur == 0 || {ic_done, dc_done} !== {cur == 1, cur == 2} || beats != BL) begin
                        errors++;
                        $display("FAIL rnd%0d_done: ic_done=%b dc_done=%b beats=%0d expected owner=%0d beats=%0d",
                                 t, ic_done, dc_done, beats, cur, BL);
                    end
                    if (ic_done) begin ic_p = 1'b0; ic_req = 1'b0; end
                    if (dc_done) begin dc_p = 1'b0; dc_req = 1'b0; end
                    cur = 0;
                end
                next_cycle();
            end
            checks++;
            if (cyc >= 200) begin
                errors++;
                $display("FAIL rnd%0d_timeout: cycles=%0d limit 200", t, cyc);
                ic_req = 1'b0; dc_req = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ic_refill();
        test_dc_writeback();
        test_tie();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory word port between the icache refill engine and the dcache refill/writeback engine.
- Each requester asks for a whole-line burst. The arbiter grants one requester, then sequences BURST_LEN single-word memory beats with a beat counter and address generator.
- Signals burst completion back to the owner, then re-arbitrates.
- Sits between the icache/dcache miss logic and the memory controller, below the core.

Parameters:
- BURST_LEN, 4, words per line burst; power of two, at least 2.
- ADDR_W, 32, address width; matches addr_t.
- DATA_W, 32, data width; matches data_t.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ic_req  in  1  icache line-read request; level, held until ic_done
- ic_addr  in  ADDR_W  icache line address; low offset bits ignored
- ic_rvalid  out  1  icache read beat valid
- ic_rdata  out  DATA_W  icache read beat data
- ic_done  out  1  one-cycle pulse, icache burst complete
- dc_req  in  1  dcache request; level, held until dc_done
- dc_we  in  1  dcache burst is a writeback (1) or refill (0)
- dc_addr  in  ADDR_W  dcache line address
- dc_wdata  in  DATA_W  writeback word for the current beat
- dc_wnext  out  1  current dc_wdata consumed; advance to next word
- dc_rvalid  out  1  dcache read beat valid
- dc_rdata  out  DATA_W  dcache read beat data
- dc_done  out  1  one-cycle pulse, dcache burst complete
- mem_valid  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address of the beat
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts the beat; read data is valid in the same cycle
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, owner=NONE, beat=0, priority pointer=dcache.
  - All outputs 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise grant a requester and latch owner, line base, and we (dc_we for dcache, 0 for icache).
  - Line base is the address with the low log2(BURST_LEN)+2 bits zeroed.
  - Set beat=0 and go to BUSY. Grant takes one cycle; no memory beat is issued in the grant cycle.
- BUSY:
  - mem_valid=1; mem_addr = base + 4*beat; mem_we = latched we; mem_wdata = dc_wdata.
  - A beat completes on a cycle with mem_valid & mem_ready.
  - On a completing read beat: owner's *_rvalid=1 and *_rdata=mem_rdata, combinationally in the same cycle.
  - On a completing write beat: dc_wnext=1.
  - beat increments on each completed beat. When the last beat (beat==BURST_LEN-1) completes, go to DONE.
  - mem_ready=0 stalls indefinitely with no state change.
- DONE:
  - Owner's *_done=1 for exactly one cycle, then go to IDLE.
  - Requester must drop req in the cycle after done; a req still high in IDLE is treated as a new request.
- Fixed priority (default, feature off): dcache wins over icache when both request in the same IDLE cycle.
- Beat counter is log2(BURST_LEN) bits and wraps to 0 after the last beat.
- Address arithmetic stays inside the line, so no carry out of the offset field.
- A requester's req dropping while it owns the bus is ignored; the burst always completes.
- Unsupported: requester changes addr or dc_we while its req is high.
- Reset mid-burst: immediate return to IDLE. Requesters are also reset, so no done pulse is issued.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A one-bit last-owner register picks the winner on a simultaneous request: the requester that was not granted last wins.
  - The register resets to icache, so dcache wins the first tie.
  - It updates on each grant.
- Undefined: fixed dcache priority; no last-owner register.
- Single requests are unaffected either way.

Decomposition:
- Shared package (mem_arb_pkg):
  - enum arb_state_t {IDLE, BUSY, DONE}
  - enum arb_owner_t {OWN_NONE, OWN_IC, OWN_DC}
  - localparam OFFSET_W = $clog2(BURST_LEN)+2
- Reuse addr_t and data_t from type_pkg.
- One natural sub-module, arb_pick: the combinational winner select, with the round-robin state gated by the macro.
- Beat counter and FSM stay in the top module.

Test Plan:
- Single icache refill:
  - Stimulus: ic_req with ic_addr=0x0000_1234, mem_ready=1.
  - Response: mem_addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles, each with ic_rvalid and mem_rdata passed through; ic_done one cycle after the last beat.
- Dcache writeback with stalls:
  - Stimulus: dc_we=1, dc_addr=0x2000; mem_ready low for 2 cycles before each beat.
  - Response: 4 writes, mem_we=1, dc_wnext pulses exactly 4 times, dc_done once.
- Simultaneous requests, feature off:
  - Stimulus: ic_req and dc_req rise together.
  - Response: dcache burst first, then icache burst granted in the IDLE cycle after dc_done.
- Simultaneous requests, MEM_ARBITER_ROUND_ROBIN_EN defined:
  - Stimulus: two back-to-back tie rounds.
  - Response: grant order DC, IC, DC, IC.
- Asynchronous reset mid-burst:
  - Stimulus: rst_n low after beat 1.
  - Response: all outputs 0 immediately; no done pulse; a new ic_req after reset release restarts at beat 0.
- Request dropped mid-burst:
  - Stimulus: ic_req deasserted during beat 2.
  - Response: the burst still completes with 4 beats and ic_done is pulsed.
